// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared NPC op codes and PC defaults for the fetch-side PC generator
// Optional feature macro used by pc_gen: PC_GEN_PERF_EN.
package pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam int          PC_STEP      = 4;

  typedef enum logic [3:0] {
    NPC_SEQ  = 4'd0,
    NPC_BEQ  = 4'd1,
    NPC_BNE  = 4'd2,
    NPC_J    = 4'd3,
    NPC_JAL  = 4'd4,
    NPC_JR   = 4'd5,
    NPC_JALR = 4'd6,
    NPC_ERET = 4'd7
  } npc_op_e;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational BR/J/JR/ERET/exception targets and redirect priority mux
module pc_target_calc
  import pc_gen_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] EXC_VEC  = EXC_VEC_DEF,
  parameter int              ERET_OFS = 4
) (
  input  logic            i_exc_req,
  input  logic [PC_W-1:0] i_epc,
  input  logic [PC_W-1:0] i_d_pc,
  input  logic [3:0]      i_npc_op,
  input  logic            i_br_taken,
  input  logic [PC_W-1:0] i_rs_data,
  input  logic [25:0]     i_ir26,
  output logic [PC_W-1:0] o_target,
  output logic            o_redirect
);

  logic [PC_W-1:0] w_br;
  logic [PC_W-1:0] w_j;
  logic [PC_W-1:0] w_eret;

  assign w_br   = i_d_pc + PC_W'(PC_STEP) + {{(PC_W-18){i_ir26[15]}}, i_ir26[15:0], 2'b00};
  assign w_j    = {i_d_pc[PC_W-1:28], i_ir26, 2'b00};
  assign w_eret = i_epc + PC_W'(ERET_OFS);

  // Exception outranks everything, including an ERET in D on the same cycle.
  always_comb begin
    o_target   = '0;
    o_redirect = 1'b0;
    if (i_exc_req) begin
      o_target   = EXC_VEC;
      o_redirect = 1'b1;
    end else begin
      case (npc_op_e'(i_npc_op))
        NPC_ERET: begin
          o_target   = w_eret;
          o_redirect = 1'b1;
        end
        NPC_JR, NPC_JALR: begin
          o_target   = i_rs_data;
          o_redirect = 1'b1;
        end
        NPC_J, NPC_JAL: begin
          o_target   = w_j;
          o_redirect = 1'b1;
        end
        NPC_BEQ, NPC_BNE: begin
          o_target   = w_br;
          o_redirect = i_br_taken;
        end
        default: begin
          o_target   = '0;
          o_redirect = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - F-stage PC register, fetch handshake and pending-redirect FSM
// Optional counters perf_redir/perf_hold are built when PC_GEN_PERF_EN is defined.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] EXC_VEC  = EXC_VEC_DEF,
  parameter int              ERET_OFS = 4,
  parameter logic [PC_W-1:0] IM_BASE  = 32'h0000_3000,
  parameter logic [PC_W-1:0] IM_SIZE  = 32'h0000_4000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            im_ready,
  input  logic            exc_req,
  input  logic [PC_W-1:0] epc,
  input  logic [PC_W-1:0] d_pc,
  input  logic [3:0]      d_npc_op,
  input  logic            d_br_taken,
  input  logic [PC_W-1:0] d_rs_data,
  input  logic [25:0]     d_ir26,
  output logic [PC_W-1:0] f_pc,
  output logic            f_valid,
  output logic            f_adel,
  output logic [PC_W-1:0] d_pc8,
  output logic            redir_pend
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0]     perf_redir,
  output logic [31:0]     perf_hold
`endif
);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pend;
  logic            r_valid;

  logic            w_advance;
  logic [PC_W-1:0] w_target;
  logic            w_redirect;
  logic [PC_W-1:0] w_seq;

  assign w_advance = ~stall & im_ready;
  assign w_seq     = r_pc + PC_W'(PC_STEP);

  pc_target_calc #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC),
    .ERET_OFS(ERET_OFS)
  ) u_calc (
    .i_exc_req (exc_req),
    .i_epc     (epc),
    .i_d_pc    (d_pc),
    .i_npc_op  (d_npc_op),
    .i_br_taken(d_br_taken),
    .i_rs_data (d_rs_data),
    .i_ir26    (d_ir26),
    .o_target  (w_target),
    .o_redirect(w_redirect)
  );

  // The first cycle after reset presents RESET_PC as a real fetch before stepping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
      r_valid <= 1'b0;
    end else if (exc_req) begin
      r_pc    <= w_target;
      r_pend  <= '0;
      r_state <= ST_RUN;
      r_valid <= 1'b1;
    end else if (!r_valid) begin
      r_valid <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_advance) begin
            r_pc <= w_redirect ? w_target : w_seq;
          end else if (w_redirect) begin
            r_pend  <= w_target;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_advance) begin
            r_pc    <= r_pend;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign f_pc       = r_pc;
  assign f_valid    = r_valid;
  assign redir_pend = (r_state == ST_HOLD);
  assign d_pc8      = d_pc + PC_W'(2 * PC_STEP);
  assign f_adel     = (r_pc[1:0] != 2'b00)
                    || ({1'b0, r_pc} <  {1'b0, IM_BASE})
                    || ({1'b0, r_pc} >= ({1'b0, IM_BASE} + {1'b0, IM_SIZE}));

`ifdef PC_GEN_PERF_EN
  logic        w_load_redir;
  logic        w_pc_held;
  logic [31:0] r_perf_redir;
  logic [31:0] r_perf_hold;

  assign w_load_redir = exc_req | (r_valid & w_advance & ((r_state == ST_HOLD) | w_redirect));
  assign w_pc_held    = ~exc_req & (~r_valid | ~w_advance);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_redir <= '0;
      r_perf_hold  <= '0;
    end else begin
      if (w_load_redir) r_perf_redir <= r_perf_redir + 32'd1;
      if (w_pc_held)    r_perf_hold  <= r_perf_hold + 32'd1;
    end
  end

  assign perf_redir = r_perf_redir;
  assign perf_hold  = r_perf_hold;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen: rule-level model plus directed literal checks
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        im_ready = 1'b1;
  logic        exc_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] d_pc = 32'h0;
  logic [3:0]  d_npc_op = 4'd0;
  logic        d_br_taken = 1'b0;
  logic [31:0] d_rs_data = 32'h0;
  logic [25:0] d_ir26 = 26'h0;
  logic [31:0] f_pc;
  logic        f_valid;
  logic        f_adel;
  logic [31:0] d_pc8;
  logic        redir_pend;
`ifdef PC_GEN_PERF_EN
  logic [31:0] perf_redir;
  logic [31:0] perf_hold;
`endif

  int checks = 0;
  int failures = 0;

  pc_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .im_ready  (im_ready),
    .exc_req   (exc_req),
    .epc       (epc),
    .d_pc      (d_pc),
    .d_npc_op  (d_npc_op),
    .d_br_taken(d_br_taken),
    .d_rs_data (d_rs_data),
    .d_ir26    (d_ir26),
    .f_pc      (f_pc),
    .f_valid   (f_valid),
    .f_adel    (f_adel),
    .d_pc8     (d_pc8),
    .redir_pend(redir_pend)
`ifdef PC_GEN_PERF_EN
    ,
    .perf_redir(perf_redir),
    .perf_hold (perf_hold)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Model: PC value, whether a fetch is live, and a queue holding at most one deferred redirect.
  logic [31:0] m_pc = 32'h0000_3000;
  bit          m_valid = 1'b0;
  logic [31:0] m_pend[$];

  function automatic logic [32:0] d_redirect();
    logic signed [31:0] ofs;
    case (d_npc_op)
      NPC_BEQ, NPC_BNE: begin
        ofs = $signed(d_ir26[15:0]);
        return {d_br_taken, d_pc + 32'd4 + ofs * 4};
      end
      NPC_J, NPC_JAL:   return {1'b1, (d_pc & 32'hF000_0000) | ({6'b0, d_ir26} * 4)};
      NPC_JR, NPC_JALR: return {1'b1, d_rs_data};
      NPC_ERET:         return {1'b1, epc + 32'd4};
      default:          return 33'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [32:0] rd;
    bit adv;
    if (!reset_n) begin
      m_pc = 32'h0000_3000;
      m_valid = 1'b0;
      m_pend.delete();
    end else begin
      rd  = d_redirect();
      adv = !stall && im_ready;
      if (exc_req) begin
        m_pc = 32'h0000_4180;
        m_pend.delete();
      end else if (m_valid) begin
        if (m_pend.size() > 0) begin
          if (adv) m_pc = m_pend.pop_front();
        end else if (adv) begin
          m_pc = rd[32] ? rd[31:0] : m_pc + 32'd4;
        end else if (rd[32]) begin
          m_pend.push_back(rd[31:0]);
        end
      end
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    longint unsigned pcl;
    pcl = m_pc;
    chk("model_f_pc", f_pc, m_pc);
    chk("model_f_valid", {31'b0, f_valid}, {31'b0, m_valid});
    chk("model_redir_pend", {31'b0, redir_pend}, {31'b0, m_pend.size() > 0});
    chk("model_f_adel", {31'b0, f_adel},
        {31'b0, (pcl % 4 != 0) || (pcl < 64'h3000) || (pcl >= 64'h7000)});
    chk("model_d_pc8", d_pc8, d_pc + 32'd8);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_f_pc", f_pc, 32'h3000);
    chk("reset_f_valid", {31'b0, f_valid}, 32'd0);
    reset_n = 1'b1;
    cyc();
    chk("first_f_pc", f_pc, 32'h3000);
    chk("first_f_valid", {31'b0, f_valid}, 32'd1);
    cyc(); chk("seq_3004", f_pc, 32'h3004);
    cyc(); chk("seq_3008", f_pc, 32'h3008);

    d_pc = 32'h3010; d_npc_op = NPC_BEQ; d_ir26 = 26'h000FFFE; d_br_taken = 1'b1;
    cyc(); chk("beq_taken", f_pc, 32'h300C);
    d_npc_op = NPC_SEQ;
    cyc(); chk("after_beq", f_pc, 32'h3010);
    d_npc_op = NPC_BNE; d_br_taken = 1'b0;
    cyc(); chk("bne_not_taken", f_pc, 32'h3014);

    d_npc_op = NPC_JAL; d_pc = 32'h3014; d_ir26 = 26'h0000C10; stall = 1'b1;
    cyc(); chk("jal_stall_hold", f_pc, 32'h3014);
    chk("jal_stall_pend", {31'b0, redir_pend}, 32'd1);
    d_ir26 = 26'h0000D00;
    cyc(); cyc(); chk("jal_no_relatch_hold", f_pc, 32'h3014);
    stall = 1'b0; d_npc_op = NPC_SEQ;
    cyc(); chk("jal_applied", f_pc, 32'h3040);
    chk("jal_pend_clear", {31'b0, redir_pend}, 32'd0);
    cyc(); chk("after_jal", f_pc, 32'h3044);

    d_npc_op = NPC_JR; d_rs_data = 32'h3100; im_ready = 1'b0;
    cyc(); cyc(); chk("jr_imwait_pend", {31'b0, redir_pend}, 32'd1);
    im_ready = 1'b1; d_npc_op = NPC_SEQ;
    cyc(); chk("jr_applied", f_pc, 32'h3100);

    d_npc_op = NPC_JR; d_rs_data = 32'h3200; stall = 1'b1;
    cyc(); chk("hold_before_exc", f_pc, 32'h3100);
    exc_req = 1'b1;
    cyc(); chk("exc_in_hold", f_pc, 32'h4180);
    chk("exc_pend_drop", {31'b0, redir_pend}, 32'd0);
    exc_req = 1'b0; stall = 1'b0; d_npc_op = NPC_SEQ;
    cyc(); chk("after_exc", f_pc, 32'h4184);

    epc = 32'h3020; d_npc_op = NPC_ERET;
    cyc(); chk("eret", f_pc, 32'h3024);
    exc_req = 1'b1;
    cyc(); chk("exc_beats_eret", f_pc, 32'h4180);
    exc_req = 1'b0;

    d_npc_op = NPC_JR; d_rs_data = 32'h3002;
    cyc(); chk("adel_misalign", {31'b0, f_adel}, 32'd1);
    d_rs_data = 32'h2FFC;
    cyc(); chk("adel_below", {31'b0, f_adel}, 32'd1);
    d_rs_data = 32'h6FFC;
    cyc(); chk("adel_top_ok", {31'b0, f_adel}, 32'd0);
    d_npc_op = NPC_SEQ;
    cyc(); chk("adel_top_edge", {31'b0, f_adel}, 32'd1);
    chk("adel_pc_advances", f_pc, 32'h7000);

    d_npc_op = NPC_JR; d_rs_data = 32'h3300; stall = 1'b1;
    cyc(); chk("hold_before_reset", {31'b0, redir_pend}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_pc", f_pc, 32'h3000);
    chk("async_reset_pend", {31'b0, redir_pend}, 32'd0);
    stall = 1'b0; d_npc_op = NPC_SEQ;
    cyc();
    reset_n = 1'b1;
    cyc(); chk("restart_pc", f_pc, 32'h3000);
    cyc(); chk("restart_seq", f_pc, 32'h3004);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
